// File: rtl/motor_dose_ctrl.sv
// Per-colour stepper dose controller: turns one-hot motor enables into step pulses
// until each colour's programmed step count is dispensed, then raises a sticky done flag.
module motor_dose_ctrl #(
    parameter int DOSE_W   = 8,
    parameter int STEP_DIV = 50000,
    parameter int PULSE_W  = 25000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DOSE_W-1:0] dose_r,
    input  logic [DOSE_W-1:0] dose_y,
    input  logic [DOSE_W-1:0] dose_b,
    input  logic [2:0]        motor_en,
    output logic              step_r,
    output logic              step_y,
    output logic              step_b,
    output logic [2:0]        flags,
    output logic              busy,
    output logic              err,
    output logic [1:0]        dbg_state_o
);

    localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(STEP_DIV - 1);
    localparam logic [DIV_W-1:0]  PULSE_CMP = DIV_W'(PULSE_W);
    localparam logic [DIV_W-1:0]  DIV_ONE   = DIV_W'(1);
    localparam logic [DOSE_W-1:0] REM_ONE   = DOSE_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [1:0]              ch_q, ch_d;
    logic [DIV_W-1:0]        div_q, div_d;
    logic [2:0][DOSE_W-1:0]  rem_q, rem_d;
    logic [2:0]              flags_q, flags_d;
    logic [2:0]              step_q, step_d;
    logic                    busy_q, busy_d;
    logic                    err_q, err_d;

    logic                    en_multi;
    logic                    en_onehot;
    logic [1:0]              en_ch;
    logic                    same_ch;

    // Channel index follows the bit order of motor_en: 2=R, 1=Y, 0=B.
    assign en_multi  = (motor_en[2] & motor_en[1]) | (motor_en[2] & motor_en[0]) |
                       (motor_en[1] & motor_en[0]);
    assign en_onehot = (|motor_en) & ~en_multi;
    assign en_ch     = motor_en[2] ? 2'd2 : (motor_en[1] ? 2'd1 : 2'd0);
    assign same_ch   = (motor_en == (3'b001 << ch_q));

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        div_d   = div_q;
        rem_d   = rem_q;
        flags_d = flags_q;
        step_d  = 3'b000;
        err_d   = en_multi;
        case (state_q)
            IDLE: begin
                if (en_onehot) begin
                    ch_d = en_ch;
                    if (flags_q[en_ch]) begin
                        state_d = HOLD;
                    end else if (rem_q[en_ch] == '0) begin
                        flags_d[en_ch] = 1'b1;
                        state_d        = HOLD;
                    end else begin
                        div_d   = '0;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                // Any change of enable abandons the partial period; only whole steps count.
                if (!same_ch) begin
                    state_d = IDLE;
                end else begin
                    if (div_q < PULSE_CMP) begin
                        step_d[ch_q] = 1'b1;
                    end
                    if (div_q == DIV_LAST) begin
                        div_d = '0;
                        if (rem_q[ch_q] != '0) begin
                            rem_d[ch_q] = rem_q[ch_q] - REM_ONE;
                        end
                        if (rem_q[ch_q] <= REM_ONE) begin
                            flags_d[ch_q] = 1'b1;
                            state_d       = HOLD;
                        end
                    end else begin
                        div_d = div_q + DIV_ONE;
                    end
                end
            end
            HOLD: begin
                if (!same_ch) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (load && (motor_en == 3'b000)) begin
            rem_d   = {dose_r, dose_y, dose_b};
            flags_d = 3'b000;
        end
        busy_d = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            ch_q    <= 2'd0;
            div_q   <= '0;
            rem_q   <= '0;
            flags_q <= 3'b000;
            step_q  <= 3'b000;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            div_q   <= div_d;
            rem_q   <= rem_d;
            flags_q <= flags_d;
            step_q  <= step_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign step_r      = step_q[2];
    assign step_y      = step_q[1];
    assign step_b      = step_q[0];
    assign flags       = flags_q;
    assign busy        = busy_q;
    assign err         = err_q;
    assign dbg_state_o = state_q;

endmodule
